// File: rtl/bus_arbiter.sv
// Round-robin arbiter between NUM_CLIENTS bus masters and a single ram slave,
// with a per-transfer watchdog that aborts transfers the slave never acknowledges.
module bus_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int NUM_CLIENTS = 4,
  parameter int TIMEOUT     = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] c_address,
  input  logic [NUM_CLIENTS-1:0]            c_rq,
  input  logic [NUM_CLIENTS-1:0]            c_wr_ni,
  input  logic [NUM_CLIENTS*DATA_WIDTH-1:0] c_dataW,
  output logic [NUM_CLIENTS-1:0]            c_ack,
  output logic [DATA_WIDTH-1:0]             c_dataR,
  output logic [ADDR_WIDTH-1:0]             s_address,
  output logic                              s_rq,
  output logic                              s_wr_ni,
  output logic [DATA_WIDTH-1:0]             s_dataW,
  input  logic                              s_ack,
  input  logic [DATA_WIDTH-1:0]             s_dataR,
  output logic [NUM_CLIENTS-1:0]            grant,
  output logic                              busy,
  output logic                              timeout_err
);

  localparam int IDX_W  = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RELEASE
  } state_t;

  state_t              state;
  logic [IDX_W-1:0]    grant_idx;
  logic [IDX_W-1:0]    last_grant;
  logic [WDOG_W-1:0]   wdog;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_valid;

  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base, input int offset);
    return IDX_W'((int'(base) + offset) % NUM_CLIENTS);
  endfunction

  // Scan from the farthest slot down to last_grant+1 so the nearest requester
  // after the previous winner overwrites any earlier candidate.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_CLIENTS; k >= 1; k--) begin
      if (c_rq[rr_index(last_grant, k)]) begin
        pick_valid = 1'b1;
        pick_idx   = rr_index(last_grant, k);
      end
    end
  end

  always_comb begin
    s_rq        = 1'b0;
    s_address   = '0;
    s_wr_ni     = 1'b0;
    s_dataW     = '0;
    c_ack       = '0;
    timeout_err = 1'b0;
    if (state == S_BUSY) begin
      s_rq        = 1'b1;
      s_address   = c_address[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
      s_wr_ni     = c_wr_ni[grant_idx];
      s_dataW     = c_dataW[grant_idx*DATA_WIDTH +: DATA_WIDTH];
      c_ack       = s_ack ? grant : '0;
      timeout_err = !s_ack && (wdog == WDOG_LAST);
    end
  end

  assign c_dataR = s_dataR;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state is only ever updated with non-blocking assignments.
      state      <= S_IDLE;
      grant      <= '0;
      grant_idx  <= '0;
      last_grant <= IDX_W'(NUM_CLIENTS - 1);
      wdog       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid) begin
            grant     <= NUM_CLIENTS'(1) << pick_idx;
            grant_idx <= pick_idx;
            state     <= S_BUSY;
          end
        end
        S_BUSY: begin
          wdog <= wdog + 1'b1;
          // An ack in the same cycle as an abort or watchdog expiry still completes the transfer.
          if (s_ack) begin
            last_grant <= grant_idx;
            state      <= S_RELEASE;
          end else if (wdog == WDOG_LAST) begin
            last_grant <= grant_idx;
            state      <= S_RELEASE;
          end else if (!c_rq[grant_idx]) begin
            state <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          grant <= '0;
          wdog  <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
